// File: rtl/pipeline_debug_sequencer.sv
// rtl/pipeline_debug_sequencer.sv - host-driven run/step/halt control and PC/register dump for the MIPS pipeline
module pipeline_debug_sequencer #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int N_REGS  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  input  logic [NB_DATA-1:0] i_pc,
  input  logic               i_halt_detected,
  output logic [NB_ADDR-1:0] o_reg_rd_addr,
  input  logic [NB_DATA-1:0] i_reg_rd_data,
  output logic               o_pipeline_enable,
  output logic               o_program_done,
  output logic               o_busy
);
  localparam int NB_BYTES = NB_DATA / 8;
  localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam int NB_WORD  = $clog2(N_REGS + 1);

  localparam logic [7:0] CMD_RUN  = 8'h72;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_HALT = 8'h68;
  localparam logic [7:0] CMD_DUMP = 8'h64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_DUMP_REQ,
    ST_DUMP_LATCH,
    ST_DUMP_SEND
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_done, w_done_nxt;
  logic [NB_DATA-1:0] r_shift, w_shift_nxt;
  logic [NB_WORD-1:0] r_word, w_word_nxt;
  logic [NB_BCNT-1:0] r_bcnt, w_bcnt_nxt;
  logic [NB_WORD-1:0] w_word_m1;
  logic               w_cmd_run, w_cmd_step, w_cmd_halt, w_cmd_dump;
  logic               w_tx_fire, w_last_byte, w_last_word;

  assign w_cmd_run  = i_rx_valid && (i_rx_data == CMD_RUN);
  assign w_cmd_step = i_rx_valid && (i_rx_data == CMD_STEP);
  assign w_cmd_halt = i_rx_valid && (i_rx_data == CMD_HALT);
  assign w_cmd_dump = i_rx_valid && (i_rx_data == CMD_DUMP);

  assign w_tx_fire   = (r_state == ST_DUMP_SEND) && i_tx_ready;
  assign w_last_byte = (r_bcnt == NB_BCNT'(NB_BYTES - 1));
  assign w_last_word = (r_word == NB_WORD'(N_REGS));
  // Word 0 is the PC, so word w carries register w-1.
  assign w_word_m1   = r_word - NB_WORD'(1);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_shift <= '0;
      r_word  <= '0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_shift <= w_shift_nxt;
      r_word  <= w_word_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = r_done;
    w_shift_nxt = r_shift;
    w_word_nxt  = r_word;
    w_bcnt_nxt  = r_bcnt;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_run && !r_done) begin
          w_state_nxt = ST_RUN;
        end else if (w_cmd_step && !r_done) begin
          w_state_nxt = ST_STEP;
        end else if (w_cmd_dump) begin
          w_shift_nxt = i_pc;
          w_word_nxt  = '0;
          w_bcnt_nxt  = '0;
          w_state_nxt = ST_DUMP_SEND;
        end
      end
      ST_RUN: begin
        if (i_halt_detected) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_cmd_halt) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (i_halt_detected) begin
          w_done_nxt = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end
      ST_DUMP_REQ: begin
        w_state_nxt = ST_DUMP_LATCH;
      end
      ST_DUMP_LATCH: begin
        w_shift_nxt = i_reg_rd_data;
        w_state_nxt = ST_DUMP_SEND;
      end
      ST_DUMP_SEND: begin
        if (w_tx_fire) begin
          w_shift_nxt = {r_shift[NB_DATA-9:0], 8'h00};
          if (w_last_byte) begin
            w_bcnt_nxt = '0;
            if (w_last_word) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_word_nxt  = r_word + NB_WORD'(1);
              w_state_nxt = ST_DUMP_REQ;
            end
          end else begin
            w_bcnt_nxt = r_bcnt + NB_BCNT'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_pipeline_enable = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign o_busy            = (r_state == ST_DUMP_REQ) || (r_state == ST_DUMP_LATCH) ||
                             (r_state == ST_DUMP_SEND);
  assign o_tx_valid        = (r_state == ST_DUMP_SEND);
  assign o_tx_data         = r_shift[NB_DATA-1 -: 8];
  assign o_reg_rd_addr     = (r_state == ST_DUMP_REQ) ? NB_ADDR'(w_word_m1) : '0;
  assign o_program_done    = r_done;

endmodule
